// File: rtl/dmem_arbiter_pkg.sv
// dmem_pkg: shared constants and types for the DataMemory arbiter
package dmem_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int NUM_WORDS = 32;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_WORDS);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port (valid/ready request plus response strobe)
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output valid, we, addr, wdata, input ready, rvalid, rdata, err);
    modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata, err);

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant with a registered preference pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       RST,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       rr_o
);

    logic rr_q, rr_d;

    // a lone requester wins; a tie goes to rr, and the pointer then prefers the loser
    always_comb begin
        gnt_o = (&req_i) ? (rr_q ? 2'b10 : 2'b01) : req_i;
        rr_d  = gnt_o[0] ? 1'b1 : gnt_o[1] ? 1'b0 : rr_q;
    end

    // preference pointer
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) rr_q <= 1'b0;
        else      rr_q <= rr_d;
    end

    assign rr_o = rr_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the DataMemory port between two requesters with a 2-stage in-order pipeline
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              RST,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        gnt;
    logic              rr;
    logic              acc, sel_err;
    owner_t            sel_owner;
    req_t              sel;
    logic              iss_vld_q, iss_vld_d, iss_we_q, iss_we_d, iss_err_q, iss_err_d;
    owner_t            iss_owner_q, iss_owner_d;
    logic              rsp_vld_q, rsp_vld_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
    owner_t            rsp_owner_q, rsp_owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [1:0]        rv;
    logic              rd_ok;

    rr_arb2 u_arb (
        .clk   (clk),
        .RST   (RST),
        .req_i ({p1.valid, p0.valid}),
        .gnt_o (gnt),
        .rr_o  (rr)
    );

    // pick the granted request and form the next issue/response stage contents
    always_comb begin
        acc         = |gnt;
        sel_owner   = owner_t'(p1.valid && (!p0.valid || rr));
        sel         = (sel_owner == PORT1) ? {p1.we, p1.addr, p1.wdata} : {p0.we, p0.addr, p0.wdata};
        sel_err     = !in_range(sel.addr);
        iss_vld_d   = acc;
        iss_owner_d = sel_owner;
        iss_we_d    = sel.we;
        iss_err_d   = sel_err;
        mem_read_d  = acc && !sel_err && !sel.we;
        mem_write_d = acc && !sel_err && sel.we;
        mem_addr_d  = (acc && !sel_err) ? sel.addr : mem_addr_q;
        mem_wdata_d = (acc && !sel_err) ? sel.wdata : mem_wdata_q;
        rsp_vld_d   = iss_vld_q;
        rsp_owner_d = iss_owner_q;
        rsp_we_d    = iss_we_q;
        rsp_err_d   = iss_err_q;
    end

    // issue and response pipeline registers; reset drops anything in flight
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            iss_vld_q   <= 1'b0;
            iss_owner_q <= PORT0;
            iss_we_q    <= 1'b0;
            iss_err_q   <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= PORT0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            iss_vld_q   <= iss_vld_d;
            iss_owner_q <= iss_owner_d;
            iss_we_q    <= iss_we_d;
            iss_err_q   <= iss_err_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

    // grants are masked in reset; read data passes straight from the memory to the owner
    always_comb begin
        rv        = {rsp_vld_q && rsp_owner_q == PORT1, rsp_vld_q && rsp_owner_q == PORT0};
        rd_ok     = !rsp_we_q && !rsp_err_q;
        p0.ready  = gnt[0] && RST;
        p1.ready  = gnt[1] && RST;
        p0.rvalid = rv[0];
        p1.rvalid = rv[1];
        p0.rdata  = (rv[0] && rd_ok) ? mem_rdata : '0;
        p1.rdata  = (rv[1] && rd_ok) ? mem_rdata : '0;
        p0.err    = rv[0] && rsp_err_q;
        p1.err    = rv[1] && rsp_err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a response-queue model
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic              clk = 1'b0;
    logic              RST = 1'b0;
    logic              mem_rst = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read, mem_write;
    int                compared = 0;
    int                mismatched = 0;

    dmem_arbiter_if p0();
    dmem_arbiter_if p1();

    dmem_arbiter dut (
        .clk       (clk),
        .RST       (RST),
        .p0        (p0),
        .p1        (p1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        return (i == 20) ? 8'hFC : 8'(i);
    endfunction

    // DataMemory stand-in: writes and registered reads at the end of the strobe cycle
    logic [DATA_W-1:0] mem [NUM_WORDS];
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= init_val(i);
            mem_rdata <= '0;
        end else begin
            if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
            if (mem_read) mem_rdata <= mem[mem_addr[4:0]];
        end
    end

    // reference model: who gets granted, and a 2-deep delay line of finished responses
    typedef struct packed {
        logic       vld;
        logic       owner;
        logic       rd;
        logic       wr;
        logic       err;
        logic [7:0] data;
    } rsp_t;

    rsp_t       s1, s2;
    logic       m_rr;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] shadow [NUM_WORDS];
    logic [1:0] g_exp;
    logic       acc_exp, own_exp, we_exp, err_exp;
    logic [7:0] a_exp, wd_exp;

    function automatic logic [1:0] exp_gnt(input logic v0, input logic v1, input logic pref);
        if (v0 && v1) return pref ? 2'b10 : 2'b01;
        return {v1, v0};
    endfunction

    always_comb begin
        g_exp   = exp_gnt(p0.valid, p1.valid, m_rr);
        acc_exp = |g_exp;
        own_exp = g_exp[1];
        we_exp  = own_exp ? p1.we : p0.we;
        a_exp   = own_exp ? p1.addr : p0.addr;
        wd_exp  = own_exp ? p1.wdata : p0.wdata;
        err_exp = int'(a_exp) >= NUM_WORDS;
    end

    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < NUM_WORDS; i++) shadow[i] <= init_val(i);
        end else if (RST && acc_exp && we_exp && !err_exp) begin
            shadow[a_exp[4:0]] <= wd_exp;
        end
    end

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            m_rr    <= 1'b0;
            s1      <= '0;
            s2      <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            s2 <= s1;
            s1 <= '{vld: acc_exp, owner: own_exp, rd: acc_exp && !we_exp && !err_exp,
                    wr: acc_exp && we_exp && !err_exp, err: err_exp,
                    data: (!we_exp && !err_exp) ? shadow[a_exp[4:0]] : 8'h00};
            if (acc_exp) m_rr <= !own_exp;
            if (acc_exp && !err_exp) begin
                m_addr  <= a_exp;
                m_wdata <= wd_exp;
            end
        end
    end

    // compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        chk("p0_ready", p0.ready, RST && g_exp[0]);
        chk("p1_ready", p1.ready, RST && g_exp[1]);
        chk("p0_rvalid", p0.rvalid, s2.vld && !s2.owner);
        chk("p1_rvalid", p1.rvalid, s2.vld && s2.owner);
        chk("p0_rdata", p0.rdata, (s2.vld && !s2.owner) ? s2.data : 8'h00);
        chk("p1_rdata", p1.rdata, (s2.vld && s2.owner) ? s2.data : 8'h00);
        chk("p0_err", p0.err, s2.vld && !s2.owner && s2.err);
        chk("p1_err", p1.err, s2.vld && s2.owner && s2.err);
        chk("mem_read", mem_read, s1.rd);
        chk("mem_write", mem_write, s1.wr);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
    end

    task automatic setp(input int n, input logic v, input logic we, input logic [7:0] a, input logic [7:0] wd);
        if (n == 0) begin
            p0.valid = v; p0.we = we; p0.addr = a; p0.wdata = wd;
        end else begin
            p1.valid = v; p1.we = we; p1.addr = a; p1.wdata = wd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        mem_rst = 1'b1;
        setp(0, 0, 0, 0, 0);
        setp(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        mem_rst = 1'b0;
        RST = 1'b1;
    endtask

    function automatic logic [7:0] rnd_addr();
        int r = $urandom_range(15);
        return (r < 12) ? 8'(r % 8) : (r < 14) ? 8'(28 + $urandom_range(7)) : 8'hFF;
    endfunction

    task automatic rnd_req(input int n);
        setp(n, $urandom_range(3) != 0, $urandom_range(1) == 1, rnd_addr(), 8'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        logic a0, a1;
        do_reset();
        // single port: write then read the same address
        setp(0, 1, 1, 8'd3, 8'hA5);
        @(negedge clk); chk("s1_wr_ready", p0.ready, 1);
        step(); setp(0, 1, 0, 8'd3, 8'h00);
        @(negedge clk); chk("s1_mem_write", mem_write, 1); chk("s1_mem_addr", mem_addr, 3); chk("s1_mem_wdata", mem_wdata, 8'hA5);
        step(); setp(0, 0, 0, 0, 0);
        @(negedge clk); chk("s1_wack_rvalid", p0.rvalid, 1); chk("s1_wack_rdata", p0.rdata, 0); chk("s1_wack_err", p0.err, 0); chk("s1_mem_read", mem_read, 1);
        step();
        @(negedge clk); chk("s1_rd_rvalid", p0.rvalid, 1); chk("s1_rd_rdata", p0.rdata, 8'hA5);
        step();
        // contention: grants alternate starting with port 0
        do_reset();
        setp(0, 1, 0, 8'd1, 0);
        setp(1, 1, 0, 8'd20, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ct_p0_ready", p0.ready, c % 2 == 0);
            chk("ct_p1_ready", p1.ready, c % 2 == 1);
            if (c == 2) begin chk("ct_p0_rvalid", p0.rvalid, 1); chk("ct_p0_rdata", p0.rdata, 8'h01); end
            if (c == 3) begin chk("ct_p1_rvalid", p1.rvalid, 1); chk("ct_p1_rdata", p1.rdata, 8'hFC); end
            step();
        end
        setp(0, 0, 0, 0, 0);
        setp(1, 0, 0, 0, 0);
        @(negedge clk); chk("ct_p0_rdata2", p0.rdata, 8'h01);
        step();
        @(negedge clk); chk("ct_p1_rdata2", p1.rdata, 8'hFC);
        step();
        // out of range reads on port 1
        setp(1, 1, 0, 8'd32, 0);
        @(negedge clk); chk("oor_ready0", p1.ready, 1);
        step(); setp(1, 1, 0, 8'hFF, 0);
        @(negedge clk); chk("oor_mem_read0", mem_read, 0); chk("oor_ready1", p1.ready, 1);
        step(); setp(1, 0, 0, 0, 0);
        @(negedge clk); chk("oor_rvalid0", p1.rvalid, 1); chk("oor_err0", p1.err, 1); chk("oor_rdata0", p1.rdata, 0); chk("oor_mem_read1", mem_read, 0);
        step();
        @(negedge clk); chk("oor_rvalid1", p1.rvalid, 1); chk("oor_err1", p1.err, 1);
        step();
        // streaming reads 0..7 on port 0
        for (int i = 0; i < 10; i++) begin
            if (i < 8) setp(0, 1, 0, 8'(i), 0);
            else setp(0, 0, 0, 0, 0);
            @(negedge clk);
            if (i < 8) chk("st_ready", p0.ready, 1);
            if (i >= 2) begin chk("st_rvalid", p0.rvalid, 1); chk("st_rdata", p0.rdata, 32'(i - 2)); end
            step();
        end
        // random traffic, requests held until accepted
        rnd_req(0);
        rnd_req(1);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            a0 = p0.valid && p0.ready;
            a1 = p1.valid && p1.ready;
            step();
            if (!p0.valid || a0) rnd_req(0);
            if (!p1.valid || a1) rnd_req(1);
        end
        setp(0, 0, 0, 0, 0);
        setp(1, 0, 0, 0, 0);
        repeat (3) step();
        // reset with two accesses in flight
        setp(0, 1, 0, 8'd5, 0);
        setp(1, 1, 1, 8'd6, 8'h3C);
        repeat (2) step();
        RST = 1'b0;
        #1;
        chk("rst_p0_ready", p0.ready, 0); chk("rst_p1_ready", p1.ready, 0);
        chk("rst_p0_rvalid", p0.rvalid, 0); chk("rst_p1_rvalid", p1.rvalid, 0);
        chk("rst_mem_read", mem_read, 0); chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_p0_rdata", p0.rdata, 0); chk("rst_p1_err", p1.err, 0);
        repeat (2) step();
        setp(0, 0, 0, 0, 0);
        setp(1, 0, 0, 0, 0);
        RST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("post_p0_rvalid", p0.rvalid, 0); chk("post_p1_rvalid", p1.rvalid, 0);
            step();
        end
        setp(0, 1, 0, 8'd2, 0);
        setp(1, 1, 0, 8'd4, 0);
        @(negedge clk); chk("post_p0_first", p0.ready, 1); chk("post_p1_first", p1.ready, 0);
        step();
        @(negedge clk); chk("post_p1_second", p1.ready, 1);
        step();
        setp(0, 0, 0, 0, 0);
        setp(1, 0, 0, 0, 0);
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
